id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-select stage feeding the RV32I ALU. It captures decoded instruction fields at the end of decode, holds them across stalls, and discards them on flush. In the EX cycle it resolves data hazards by forwarding from EX/MEM and MEM/WB, then drives the ALU's `in1`, `in2` and `alu_ctrl` directly.

---
 rtl/rv32i_pkg.sv | 24 ++
 rtl/fwd_mux.sv | 36 +++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU opcode encoding, operand-select codes and
// default datapath widths.
package rv32i_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RAW_DEF  = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic SRC1_RS1 = 1'b0;
    localparam logic SRC1_PC  = 1'b1;
    localparam logic SRC2_RS2 = 1'b0;
    localparam logic SRC2_IMM = 1'b1;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding mux for one source operand: EX/MEM beats MEM/WB beats the held
// register-file value; x0 is never forwarded.
module fwd_mux
    import rv32i_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RAW  = RAW_DEF
) (
    input  logic [RAW-1:0]  addr,
    input  logic [XLEN-1:0] held,
    input  logic            exmem_we,
    input  logic [RAW-1:0]  exmem_rd,
    input  logic [XLEN-1:0] exmem_rslt,
    input  logic            memwb_we,
    input  logic [RAW-1:0]  memwb_rd,
    input  logic [XLEN-1:0] memwb_data,
    output logic [XLEN-1:0] fwd
);

    logic hit_exmem;
    logic hit_memwb;

    assign hit_exmem = exmem_we && (exmem_rd != '0) && (exmem_rd == addr);
    assign hit_memwb = memwb_we && (memwb_rd != '0) && (memwb_rd == addr);

    always_comb begin
        // NOTE: default assignment first so every path drives fwd; no latch.
        fwd = held;
        if (hit_exmem) begin
            fwd = exmem_rslt;
        end else if (hit_memwb) begin
            fwd = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control and EX-stage operand
// forwarding feeding the ALU inputs directly.
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RAW  = RAW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [RAW-1:0]  id_rs1_addr,
    input  logic [RAW-1:0]  id_rs2_addr,
    input  logic [RAW-1:0]  id_rd_addr,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_src1_sel,
    input  logic            id_src2_sel,
    input  logic            id_reg_we,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_we,
    input  logic [RAW-1:0]  exmem_rd,
    input  logic [XLEN-1:0] exmem_rslt,
    input  logic            memwb_we,
    input  logic [RAW-1:0]  memwb_rd,
    input  logic [XLEN-1:0] memwb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] in1,
    output logic [XLEN-1:0] in2,
    output logic [3:0]      alu_ctrl,
    output logic [RAW-1:0]  ex_rd_addr,
    output logic            ex_reg_we,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc
);

    logic            valid_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [RAW-1:0]  rs1_addr_q;
    logic [RAW-1:0]  rs2_addr_q;
    logic [RAW-1:0]  rd_addr_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] pc_q;
    logic [3:0]      alu_ctrl_q;
    logic            src1_sel_q;
    logic            src2_sel_q;
    logic            reg_we_q;

    logic            memwb_live;
    logic            refresh_rs1;
    logic            refresh_rs2;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // A producer retiring during a stall must update the held operand, or
    // its value vanishes once MEM/WB moves on.
    assign memwb_live  = memwb_we && (memwb_rd != '0);
    assign refresh_rs1 = valid_q && memwb_live && (memwb_rd == rs1_addr_q);
    assign refresh_rs2 = valid_q && memwb_live && (memwb_rd == rs2_addr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            alu_ctrl_q <= ALU_ADD;
            src1_sel_q <= SRC1_RS1;
            src2_sel_q <= SRC2_RS2;
            reg_we_q   <= 1'b0;
        end else if (flush) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values regardless of statement order.
            valid_q    <= 1'b0;
            reg_we_q   <= 1'b0;
            alu_ctrl_q <= ALU_ADD;
        end else if (stall) begin
            if (refresh_rs1) rs1_data_q <= memwb_data;
            if (refresh_rs2) rs2_data_q <= memwb_data;
        end else begin
            valid_q    <= id_valid;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            rs1_addr_q <= id_rs1_addr;
            rs2_addr_q <= id_rs2_addr;
            rd_addr_q  <= id_rd_addr;
            imm_q      <= id_imm;
            pc_q       <= id_pc;
            alu_ctrl_q <= id_alu_ctrl;
            src1_sel_q <= id_src1_sel;
            src2_sel_q <= id_src2_sel;
            reg_we_q   <= id_reg_we;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs1 (
        .addr       (rs1_addr_q),
        .held       (rs1_data_q),
        .exmem_we   (exmem_we),
        .exmem_rd   (exmem_rd),
        .exmem_rslt (exmem_rslt),
        .memwb_we   (memwb_we),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .fwd        (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs2 (
        .addr       (rs2_addr_q),
        .held       (rs2_data_q),
        .exmem_we   (exmem_we),
        .exmem_rd   (exmem_rd),
        .exmem_rslt (exmem_rslt),
        .memwb_we   (memwb_we),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .fwd        (fwd_rs2)
    );

    assign in1           = (src1_sel_q == SRC1_PC)  ? pc_q  : fwd_rs1;
    assign in2           = (src2_sel_q == SRC2_IMM) ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = valid_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_we     = reg_we_q & valid_q;
    assign ex_pc         = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table of single-instruction vectors
// plus directed reset, stall-refresh and flush sequences.
module tb_id_ex_stage;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_imm, id_pc;
    logic [3:0]  id_alu_ctrl;
    logic        id_src1_sel, id_src2_sel, id_reg_we;
    logic        stall, flush;
    logic        exmem_we;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_rslt;
    logic        memwb_we;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        ex_valid;
    logic [31:0] in1, in2;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_we;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.XLEN(32), .RAW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_imm(id_imm), .id_pc(id_pc), .id_alu_ctrl(id_alu_ctrl),
        .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel), .id_reg_we(id_reg_we),
        .stall(stall), .flush(flush),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_rslt(exmem_rslt),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .ex_valid(ex_valid), .in1(in1), .in2(in2), .alu_ctrl(alu_ctrl),
        .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] rs1_d, rs2_d;
        logic [4:0]  a1, a2, rd;
        logic [31:0] imm, pc;
        logic [3:0]  alu;
        logic        s1, s2, we;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xr;
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic [31:0] e_in1, e_in2, e_st;
        logic        e_valid, e_we;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_wb();
        exmem_we = 1'b0; exmem_rd = '0; exmem_rslt = '0;
        memwb_we = 1'b0; memwb_rd = '0; memwb_data = '0;
    endtask

    task automatic drive_id(input logic vld, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] alu,
                            input logic s1, input logic s2, input logic we);
        id_valid = vld; id_rs1_data = d1; id_rs2_data = d2;
        id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd;
        id_imm = imm; id_pc = pc; id_alu_ctrl = alu;
        id_src1_sel = s1; id_src2_sel = s2; id_reg_we = we;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd0);
        check({tag, ".in1"}, in1, 32'd0);
        check({tag, ".in2"}, in2, 32'd0);
        check({tag, ".alu_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
        check({tag, ".ex_rd_addr"}, {27'd0, ex_rd_addr}, 32'd0);
        check({tag, ".ex_reg_we"}, {31'd0, ex_reg_we}, 32'd0);
        check({tag, ".ex_store_data"}, ex_store_data, 32'd0);
        check({tag, ".ex_pc"}, ex_pc, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd10, 32'd0, 32'h40, ALU_ADD, 1'b0, 1'b0, 1'b1,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 32'd1, 32'd2, 5'd3, 5'd4, 5'd11, 32'd0, 32'h44, ALU_ADD, 1'b0, 1'b0, 1'b1,
                    1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 32'h11, 32'd2, 32'd2, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 32'd1, 32'd2, 5'd3, 5'd4, 5'd11, 32'd0, 32'h44, ALU_ADD, 1'b0, 1'b0, 1'b1,
                    1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 32'h22, 32'd2, 32'd2, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'd8, 32'd0, 5'd5, 5'd0, 5'd12, 32'd0, 32'h48, ALU_SUB, 1'b0, 1'b0, 1'b1,
                    1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 32'd8, 32'd0, 32'd0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'd3, 32'd9, 5'd1, 5'd4, 5'd13, 32'hFFFF_FFFC, 32'h100, ALU_ADD,
                    SRC1_PC, SRC2_IMM, 1'b1,
                    1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h77, 32'h100, 32'hFFFF_FFFC, 32'h77, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'd1, 32'd2, 5'd1, 5'd2, 5'd14, 32'd0, 32'h50, ALU_OR, 1'b0, 1'b0, 1'b1,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1, 32'd2, 32'd2, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h20, 32'h30, 5'd7, 5'd8, 5'd15, 32'd0, 32'h54, 4'hF, 1'b0, 1'b0, 1'b0,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h20, 32'h30, 32'h30, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 32'd1, 32'd2, 5'd5, 5'd6, 5'd16, 32'd0, 32'h58, ALU_XOR, 1'b0, 1'b0, 1'b1,
                    1'b1, 5'd7, 32'h99, 1'b1, 5'd6, 32'hAB, 32'd1, 32'hAB, 32'hAB, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 32'h12, 32'h34, 5'd9, 5'd10, 5'd17, 32'd0, 32'h5C, ALU_SLT, 1'b0, 1'b0, 1'b1,
                    1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 32'hEE, 32'h12, 32'h34, 32'h34, 1'b1, 1'b1};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, ALU_ADD, 1'b0, 1'b0, 1'b0);
        idle_wb();
        #12;
        check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: load one instruction, then present the EX-cycle writeback ports.
        for (int i = 0; i < 9; i++) begin
            idle_wb();
            drive_id(vecs[i].vld, vecs[i].rs1_d, vecs[i].rs2_d, vecs[i].a1, vecs[i].a2, vecs[i].rd,
                     vecs[i].imm, vecs[i].pc, vecs[i].alu, vecs[i].s1, vecs[i].s2, vecs[i].we);
            @(posedge clk); #1;
            exmem_we = vecs[i].xw; exmem_rd = vecs[i].xrd; exmem_rslt = vecs[i].xr;
            memwb_we = vecs[i].mw; memwb_rd = vecs[i].mrd; memwb_data = vecs[i].md;
            #1;
            check($sformatf("v%0d.in1", i), in1, vecs[i].e_in1);
            check($sformatf("v%0d.in2", i), in2, vecs[i].e_in2);
            check($sformatf("v%0d.store", i), ex_store_data, vecs[i].e_st);
            check($sformatf("v%0d.valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("v%0d.reg_we", i), {31'd0, ex_reg_we}, {31'd0, vecs[i].e_we});
            check($sformatf("v%0d.alu", i), {28'd0, alu_ctrl}, {28'd0, vecs[i].alu});
            check($sformatf("v%0d.rd", i), {27'd0, ex_rd_addr}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d.pc", i), ex_pc, vecs[i].pc);
        end

        // Mid-run reset, then first load after release.
        idle_wb();
        drive_id(1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 32'd0, 32'h200, ALU_ADD, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst");
        @(negedge clk);
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel.in1", in1, 32'd5);
        check("rel.in2", in2, 32'd7);
        check("rel.alu", {28'd0, alu_ctrl}, 32'd0);
        check("rel.valid", {31'd0, ex_valid}, 32'd1);

        // Stall with refresh: held rs1 = x9 (0x1); producer retires in stall cycle 2.
        drive_id(1'b1, 32'h1, 32'h2, 5'd9, 5'd2, 5'd4, 32'd0, 32'h300, ALU_SUB, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        stall = 1'b1;
        drive_id(1'b1, 32'hBAD, 32'hBEE, 5'd2, 5'd3, 5'd5, 32'd0, 32'h400, ALU_OR, 1'b0, 1'b0, 1'b1);
        #1;
        check("stl1.in1", in1, 32'h1);
        @(posedge clk); #1;
        memwb_we = 1'b1; memwb_rd = 5'd9; memwb_data = 32'h55;
        #1;
        check("stl2.in1_fwd", in1, 32'h55);
        check("stl2.pc", ex_pc, 32'h300);
        @(posedge clk); #1;
        idle_wb();
        #1;
        check("stl3.in1", in1, 32'h55);
        check("stl3.alu", {28'd0, alu_ctrl}, {28'd0, ALU_SUB});
        check("stl3.rd", {27'd0, ex_rd_addr}, 32'd4);
        @(posedge clk); #1;
        stall = 1'b0;
        #1;
        check("stlrel.in1", in1, 32'h55);
        check("stlrel.pc", ex_pc, 32'h300);
        @(posedge clk); #1;
        check("after.in1", in1, 32'hBAD);
        check("after.pc", ex_pc, 32'h400);

        // Flush beats stall.
        drive_id(1'b1, 32'h1, 32'h2, 5'd1, 5'd2, 5'd6, 32'd0, 32'h500, ALU_SUB, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("pre_flush.alu", {28'd0, alu_ctrl}, {28'd0, ALU_SUB});
        flush = 1'b1; stall = 1'b1;
        drive_id(1'b1, 32'h3, 32'h4, 5'd1, 5'd2, 5'd7, 32'd0, 32'h600, ALU_XOR, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush.valid", {31'd0, ex_valid}, 32'd0);
        check("flush.reg_we", {31'd0, ex_reg_we}, 32'd0);
        check("flush.alu", {28'd0, alu_ctrl}, 32'd0);

        // Stall on an empty slot keeps it empty.
        memwb_we = 1'b1; memwb_rd = 5'd1; memwb_data = 32'h66;
        @(posedge clk); #1;
        idle_wb();
        stall = 1'b0;
        #1;
        check("bubble_stall.valid", {31'd0, ex_valid}, 32'd0);
        check("bubble_stall.reg_we", {31'd0, ex_reg_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
